// File: rtl/binomial_filter_seq.sv
// Frame sequencer for a free-running N-stage binomial filter.
// Accepts framed samples on a valid/ready stream and feeds them to the filter
// one per cycle, driving zeros when there is no sample. After each frame it
// appends N zero samples so the full (1+z^-1)^N response comes out. The filter
// has no reset, so after reset it is first flushed with zeros for long enough
// to clear its internal state. A (valid,last) tag pipe runs alongside the
// filter and marks which filter outputs belong to a frame.
module binomial_filter_seq #(
    parameter int N   = 4,
    parameter int DW  = 8,
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] filt_inp,
    input  logic [DW-1:0] filt_outp,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    output logic          busy
);

    // Zero samples needed to push all filter history and pipeline contents out.
    localparam int PRIME_LEN = LAT + N + 1;
    localparam int PW        = $clog2(PRIME_LEN + 1);
    localparam int FW        = $clog2(N + 1);

    localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_LEN - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(N - 1);

    localparam logic [1:0] ST_PRIME = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic [PW-1:0] prime_cnt_q, prime_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [DW-1:0] filt_inp_q,  filt_inp_d;

    // Tag stage 0 is registered together with filt_inp; stage LAT lines up
    // with the filter output that sample produces.
    logic [LAT:0]  tag_valid_q, tag_valid_d;
    logic [LAT:0]  tag_last_q,  tag_last_d;
    logic          tag_in_valid;
    logic          tag_in_last;

    logic [DW-1:0] out_data_q;
    logic          out_valid_q;
    logic          out_last_q;

    logic          ready_int;
    logic          xfer;

    assign ready_int = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign xfer      = in_valid && ready_int;

    // Sequencer: next state, counters and the sample/tag injected this cycle.
    always_comb begin
        state_d      = state_q;
        prime_cnt_d  = prime_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        filt_inp_d   = '0;
        tag_in_valid = 1'b0;
        tag_in_last  = 1'b0;
        case (state_q)
            ST_PRIME: begin
                if (prime_cnt_q == PRIME_LAST) begin
                    state_d     = ST_IDLE;
                    prime_cnt_d = '0;
                end else begin
                    prime_cnt_d = prime_cnt_q + 1'b1;
                end
            end
            ST_IDLE, ST_RUN: begin
                // Without a transfer a RUN cycle becomes an untagged zero
                // (bubble) inside the frame; in IDLE it is just idle fill.
                if (xfer) begin
                    filt_inp_d   = in_data;
                    tag_in_valid = 1'b1;
                    if (in_last) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                // Flush zeros are real output positions of the frame.
                tag_in_valid = 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    tag_in_last = 1'b1;
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_PRIME;
                prime_cnt_d = '0;
            end
        endcase
    end

    // Tag shift register: entry from the sequencer, then one stage per cycle.
    assign tag_valid_d[0] = tag_in_valid;
    assign tag_last_d[0]  = tag_in_last;
    generate
        for (genvar gi = 1; gi <= LAT; gi++) begin : g_tag_pipe
            assign tag_valid_d[gi] = tag_valid_q[gi-1];
            assign tag_last_d[gi]  = tag_last_q[gi-1];
        end
    endgenerate

    // Sequencer state, counters and the registered filter input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PRIME;
            prime_cnt_q <= '0;
            flush_cnt_q <= '0;
            filt_inp_q  <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            filt_inp_q  <= filt_inp_d;
        end
    end

    // Tag pipe advances every cycle; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
            tag_last_q  <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_last_q  <= tag_last_d;
        end
    end

    // Output register: data follows the filter every cycle, tags qualify it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_data_q  <= filt_outp;
            out_valid_q <= tag_valid_q[LAT];
            out_last_q  <= tag_valid_q[LAT] && tag_last_q[LAT];
        end
    end

    assign in_ready  = ready_int;
    assign filt_inp  = filt_inp_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE) || (|tag_valid_q) || out_valid_q;

endmodule

// File: tb/tb_binomial_filter_seq.sv
// Bench for binomial_filter_seq: includes a behavioural model of the
// unreset binomial filter, a frame-level model of the expected output beats
// (value, last flag, arrival cycle) and directed frames with literal results.
module tb_binomial_filter_seq;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int LAT       = 4;
    localparam int PRIME_LEN = LAT + N + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] filt_inp;
    logic [DW-1:0] filt_outp;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int data;
        int last;
        int cyc;
    } beat_t;

    beat_t exp_q[$];
    int    got_d[$];
    int    got_l[$];

    binomial_filter_seq #(.N(N), .DW(DW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .filt_inp  (filt_inp),
        .filt_outp (filt_outp),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // Filter model: no reset, starts full of junk. Output in a cycle is the
    // binomial-weighted sum of filt_inp from LAT..LAT+N cycles earlier.
    logic [DW-1:0] hist [LAT+N] = '{default: 8'hA5};

    always @(posedge clk) begin
        hist[0] <= filt_inp;
        for (int i = 1; i < LAT + N; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        int acc;
        acc = 0;
        for (int k = 0; k <= N; k++) acc = acc + binom(N, k) * int'(hist[LAT-1+k]);
        filt_outp = DW'(acc);
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output compare: every cycle, any valid beat must be the next expected
    // one, with matching data, last flag and arrival cycle.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                got_d.push_back(int'(out_data));
                got_l.push_back(int'(out_last));
                $display("[TB] beat cyc=%0d data=%0d last=%0d", cyc, out_data, out_last);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0d, expected no beat (cycle %0d)", out_data, cyc);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", int'(out_data), b.data);
                    check("beat_last", int'(out_last), b.last);
                    check("beat_cycle", cyc, b.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                b = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL beat_missing: got none by cycle %0d, expected data %0d at cycle %0d", cyc, b.data, b.cyc);
            end
        end
    end

    // Send one frame (negative entries are one-cycle bubbles); the frame
    // model computes every expected beat before the first sample goes out.
    task automatic send_frame(input int vals[$]);
        int    k;
        int    x[$];
        int    t0;
        int    len;
        int    acc;
        int    last_real;
        beat_t b;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("wait_in_ready", int'(in_ready), 1);
        t0 = cyc;
        last_real = 0;
        foreach (vals[i]) begin
            x.push_back(vals[i] < 0 ? 0 : vals[i]);
            if (vals[i] >= 0) last_real = i;
        end
        for (int i = 0; i < N; i++) x.push_back(0);
        len = x.size();
        for (int p = 0; p < len; p++) begin
            if (p >= vals.size() || vals[p] >= 0) begin
                acc = 0;
                for (int j = 0; j <= N; j++)
                    if (p - j >= 0) acc = acc + binom(N, j) * x[p-j];
                b.data = acc % 256;
                b.last = (p == len - 1) ? 1 : 0;
                b.cyc  = t0 + p + LAT + 2;
                exp_q.push_back(b);
            end
        end
        foreach (vals[i]) begin
            if (vals[i] < 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 8'd0;
            end else begin
                check("in_ready_run", int'(in_ready), 1);
                in_valid = 1'b1;
                in_data  = DW'(vals[i]);
                in_last  = (i == last_real);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'd0;
        $display("[TB] frame sent at cycle %0d, %0d entries", t0, vals.size());
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain", int'(exp_q.size() == 0 && !busy), 1);
    endtask

    task automatic check_got(input string name, input int ed[$], input int el[$]);
        check({name, "_count"}, got_d.size(), ed.size());
        if (got_d.size() == ed.size()) begin
            foreach (ed[i]) begin
                check({name, "_data"}, got_d[i], ed[i]);
                check({name, "_last"}, got_l[i], el[i]);
            end
        end
        got_d.delete();
        got_l.delete();
    endtask

    initial begin
        int edges;
        int ed[$];
        int el[$];
        int fr[$];
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_filt_inp", int'(filt_inp), 0);
        check("rst_busy", int'(busy), 1);
        rst = 1'b0;

        // Priming: zeros for PRIME_LEN cycles after the last reset edge, then IDLE.
        edges = 0;
        while (edges < 100) begin
            @(negedge clk);
            edges++;
            if (in_ready) break;
            check("prime_filt_inp", int'(filt_inp), 0);
            check("prime_out_valid", int'(out_valid), 0);
            check("prime_busy", int'(busy), 1);
        end
        check("prime_edges", edges, PRIME_LEN);
        check("idle_busy", int'(busy), 0);

        // Impulse
        fr = '{1};
        send_frame(fr);
        wait_drain();
        ed = '{1, 4, 6, 4, 1};
        el = '{0, 0, 0, 0, 1};
        check_got("impulse", ed, el);

        // [2,2]; in_valid held high during FLUSH must be ignored
        fr = '{2, 2};
        send_frame(fr);
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < N; i++) begin
            check("flush_in_ready", int'(in_ready), 0);
            if (i == N - 1) in_valid = 1'b0;
            @(negedge clk);
        end
        in_data = 8'd0;
        check("post_flush_in_ready", int'(in_ready), 1);
        wait_drain();
        ed = '{2, 10, 20, 20, 10, 2};
        el = '{0, 0, 0, 0, 0, 1};
        check_got("two", ed, el);

        // Wrap-around: 255*[1,5,10,10,5,1] mod 256
        fr = '{255, 255};
        send_frame(fr);
        wait_drain();
        ed = '{255, 251, 246, 246, 251, 255};
        el = '{0, 0, 0, 0, 0, 1};
        check_got("wrap", ed, el);

        // Bubble frame [1,gap,1]: conv [1,4,7,8,7,4,1], gap position gives no
        // beat; then [3,5] starts while the first frame is still in flight.
        fr = '{1, -1, 1};
        send_frame(fr);
        fr = '{3, 5};
        send_frame(fr);
        check("inflight_busy", int'(busy), 1);
        wait_drain();
        ed = '{1, 7, 8, 7, 4, 1, 3, 17, 38, 42, 23, 5};
        el = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        check_got("bubble_then_next", ed, el);

        // Reset in the second FLUSH cycle aborts the frame without any beat.
        fr = '{7, 9};
        send_frame(fr);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_busy", int'(busy), 1);
        @(negedge clk);
        rst = 1'b0;
        check("abort_no_beats", got_d.size(), 0);
        fr = '{1};
        send_frame(fr);
        wait_drain();
        ed = '{1, 4, 6, 4, 1};
        el = '{0, 0, 0, 0, 1};
        check_got("after_abort", ed, el);

        check("end_busy", int'(busy), 0);
        check("end_exp_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
